config_memory_unit: RTL
=======================

// Module: config_memory_unit
// PURPOSE
//  Downstream stage of the password-gated control unit. Commits each 35-bit config
//  word presented with write_en into a circular history buffer. Drives the active
//  (newest) config and the 2-bit system key that the control unit compares against.
//  Provides a 1-cycle-latency readback port for past configs, indexed by age.
// PARAMETERS
//  DEPTH     8      history entries; power of 2, >=2
//  CFG_W     35     config word width
//  KEY_W     2      syskey width; key = configin[KEY_W-1:0]
//  KEY_INIT  2'b10  syskey value after reset, until the first commit
// PORTS
//  clk         in   1               clock, posedge
//  arst_n      in   1               async reset, active-low
//  write_en    in   1               commit strobe; one word per high cycle
//  configin    in   CFG_W           word to commit
//  rd_en       in   1               readback request
//  rd_idx      in   $clog2(DEPTH)   age of entry: 0 = newest
//  rd_data     out  CFG_W           readback word, valid when rd_valid=1
//  rd_valid    out  1               1-cycle pulse, the cycle after rd_en
//  rd_err      out  1               with rd_valid: rd_idx >= count
//  rd_perr     out  1               with rd_valid: parity mismatch (CFG_PARITY_EN)
//  active_cfg  out  CFG_W           newest committed word; 0 when empty
//  syskey      out  KEY_W           current key, to control unit
//  count       out  $clog2(DEPTH)+1 valid entries, saturates at DEPTH
//  full        out  1               count == DEPTH
//  wr_total    out  8               commits since reset, saturates at 255
// BEHAVIOUR
//  - Reset (arst_n low, async): wr_ptr=0, count=0, wr_total=0, active_cfg=0,
//    rd_data=0, rd_valid=0, rd_err=0, rd_perr=0, syskey=KEY_INIT. Array contents
//    are not cleared; count gates validity.
//  - Commit: posedge with write_en=1 -> mem[wr_ptr]<=configin; wr_ptr<=wr_ptr+1
//    mod DEPTH; count+=1 unless full; wr_total+=1 unless 255.
//    active_cfg<=configin and syskey<=configin[KEY_W-1:0] in the same edge, so the
//    new key is visible the cycle after the commit.
//  - Back-to-back commits: one is accepted every cycle. No backpressure.
//  - Full: commit overwrites the oldest entry. count stays DEPTH; full stays 1.
//  - Read: rd_en at edge N -> at edge N+1 rd_valid=1 and rd_data=mem[(wr_ptr-1-rd_idx)
//    mod DEPTH]. Address uses wr_ptr before any same-cycle commit (read-before-write).
//    If rd_idx >= count: rd_data=0, rd_err=1. rd_valid low -> rd_err=0, rd_perr=0,
//    and rd_data holds its last value.
//  - Simultaneous rd_en and write_en: both proceed. Read returns pre-commit history.
//  - Reset mid-operation: any pending read is dropped (rd_valid=0). Key reverts to
//    KEY_INIT.
//  - No FSM beyond the pointer/count; this is deliberate. The control unit owns
//    sequencing.
// CONFIGURATION
//  CFG_PARITY_EN defined:
//    - each entry stores an extra even-parity bit over configin, written at commit.
//    - the readback path recomputes parity; rd_perr=1 with rd_valid on mismatch.
//    - rd_err takes precedence: rd_perr=0 when rd_err=1.
//  CFG_PARITY_EN undefined:
//    - no parity storage; rd_perr is tied to 0.
// STRUCTURE
//  - Package cfg_mem_pkg: CFG_W, KEY_W, KEY_INIT constants; the age->address
//    function; the parity function.
//  - Sub-module cfg_history_ram: DEPTH x (CFG_W[+1]) array with a sync write port
//    and a registered read port. Pointer, count and key logic live in the top.
// TESTING
//  1 Reset, no writes:
//    - syskey=2'b10, count=0, active_cfg=0.
//    - rd_en with rd_idx=0 -> next cycle rd_valid=1, rd_err=1, rd_data=0.
//  2 Commit 35'h0_0000_0005:
//    - next cycle active_cfg=5, syskey=2'b01, count=1.
//    - read rd_idx=0 -> rd_data=5, rd_err=0.
//  3 Commit values 1..10 back-to-back with DEPTH=8:
//    - count=8, full=1, wr_total=10.
//    - rd_idx=0 -> 10; rd_idx=7 -> 3.
//  4 Same-cycle rd_en(rd_idx=0) and commit of 0x7 while newest=0x6:
//    - rd_data=0x6.
//    - next read with rd_idx=0 -> 0x7.
//  5 Issue rd_en, then drive arst_n low before the next edge:
//    - rd_valid=0; syskey=2'b10; count=0.
//    - 300 commits after reset -> wr_total=255.
//  6 CFG_PARITY_EN defined: force-flip bit 4 of mem[0] after one commit.
//    - read rd_idx=0 -> rd_perr=1.
//    - same test with the macro undefined -> rd_perr=0.

Source files
------------

// File: rtl/cfg_mem_pkg.sv
// Shared constants and helpers for the config memory unit: word/key widths,
// reset key, age-to-address mapping and the even-parity function.
package cfg_mem_pkg;

    localparam int              CFG_W     = 35;
    localparam int              KEY_W     = 2;
    localparam logic [KEY_W-1:0] KEY_INIT = 2'b10;
    localparam int              DEPTH_DEF = 8;

    // Age 0 is the slot just behind the write pointer; depth must be a power of 2.
    function automatic int unsigned age_to_addr(input int unsigned wr_ptr,
                                                input int unsigned age,
                                                input int unsigned depth);
        return (wr_ptr - 32'd1 - age) & (depth - 32'd1);
    endfunction

    function automatic logic cfg_parity(input logic [CFG_W-1:0] cfg);
        return ^cfg;
    endfunction

endpackage

// File: rtl/cfg_history_ram.sv
// History storage: DEPTH x W array, synchronous write, registered read with
// a clear input so the read register can return zero for out-of-range ages.
module cfg_history_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 35,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          rclr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the owner's count gates validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents when the same slot is written this edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rclr ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/config_memory_unit.sv
// Config history buffer with active config, system key and age-indexed readback.
// Optional CFG_PARITY_EN adds a stored even-parity bit checked on readback.
module config_memory_unit
    import cfg_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     write_en,
    input  logic [CFG_W-1:0]         configin,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [CFG_W-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     rd_err,
    output logic                     rd_perr,
    output logic [CFG_W-1:0]         active_cfg,
    output logic [KEY_W-1:0]         syskey,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [7:0]               wr_total
);

    localparam int AW = $clog2(DEPTH);
`ifdef CFG_PARITY_EN
    localparam int MEM_W = CFG_W + 1;
`else
    localparam int MEM_W = CFG_W;
`endif

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_addr;
    logic             rd_miss;
    logic [MEM_W-1:0] wdata;
    logic [MEM_W-1:0] rdata_raw;

    // Read handshake: rd_en is always accepted (no ready); rd_valid pulses for
    // exactly one cycle after it, qualifying rd_data, rd_err and rd_perr.
    assign rd_miss = {1'b0, rd_idx} >= count;
    assign rd_addr = AW'(age_to_addr(32'(wr_ptr), 32'(rd_idx), DEPTH));
    assign full    = (count == (AW+1)'(DEPTH));

`ifdef CFG_PARITY_EN
    assign wdata   = {cfg_parity(configin), configin};
    assign rd_perr = rd_valid & ~rd_err &
                     (cfg_parity(rdata_raw[CFG_W-1:0]) != rdata_raw[CFG_W]);
`else
    assign wdata   = configin;
    assign rd_perr = 1'b0;
`endif

    assign rd_data = rdata_raw[CFG_W-1:0];

    cfg_history_ram #(
        .DEPTH (DEPTH),
        .W     (MEM_W),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .arst_n (arst_n),
        .we     (write_en),
        .waddr  (wr_ptr),
        .wdata  (wdata),
        .re     (rd_en),
        .raddr  (rd_addr),
        .rclr   (rd_miss),
        .rdata  (rdata_raw)
    );

    // Read metadata uses the pre-commit count so a same-cycle write is invisible.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            count      <= '0;
            wr_total   <= '0;
            active_cfg <= '0;
            syskey     <= KEY_INIT;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr     <= wr_ptr + AW'(1);
                active_cfg <= configin;
                syskey     <= configin[KEY_W-1:0];
                if (!full) begin
                    count <= count + (AW+1)'(1);
                end
                if (wr_total != 8'hFF) begin
                    wr_total <= wr_total + 8'd1;
                end
            end
            rd_valid <= rd_en;
            rd_err   <= rd_en & rd_miss;
        end
    end

endmodule
